// File: rtl/clock_pkg.sv
// Shared types and constants for the clock alarm/chime blocks.
// State encoding, BCD limits and second-counter width.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_59 = 8'h59;

  localparam int SEC_CNT_W = 10;

endpackage

// File: rtl/alarm_chime_ctrl_if.sv
// Time-of-day and alarm setpoint bus, BCD encoded.
// The setting logic drives it as master; comparators read it as slave.
interface alarm_chime_ctrl_if;

  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;

  modport master (
    output hour, minute, second,
    output alarm_hour, alarm_min
  );

  modport slave (
    input hour, minute, second,
    input alarm_hour, alarm_min
  );

endinterface

// File: rtl/alarm_match.sv
// Combinational raw-byte compare of time against the alarm setpoint.
// Fires only on the :00 second so a match lasts one second.
module alarm_match
  import clock_pkg::*;
(
  alarm_chime_ctrl_if.slave bus,
  output logic              match
);

  assign match = (bus.hour   == bus.alarm_hour) &&
                 (bus.minute == bus.alarm_min)  &&
                 (bus.second == BCD_00);

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Alarm ring/snooze sequencer with hourly chime request.
// Define HOURLY_CHIME_EN to build the chime; otherwise shouldTick is 0.
module alarm_chime_ctrl
  import clock_pkg::*;
#(
  parameter int         RING_SEC        = 60,
  parameter int         SNOOZE_SEC      = 300,
  parameter int         MAX_SNOOZE      = 3,
  parameter logic [7:0] CHIME_FIRST_SEC = 8'h55
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       CP_1Hz,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       isTimeUp,
  output logic       shouldTick,
  output logic       snoozing
);

  localparam logic [SEC_CNT_W-1:0] RING_LAST =
    SEC_CNT_W'(RING_SEC - 1);
  localparam logic [SEC_CNT_W-1:0] SNZ_LAST =
    SEC_CNT_W'(SNOOZE_SEC - 1);
  localparam logic [1:0] MAX_S = 2'(MAX_SNOOZE);

  alarm_chime_ctrl_if tm ();

  assign tm.hour       = hour;
  assign tm.minute     = minute;
  assign tm.second     = second;
  assign tm.alarm_hour = alarm_hour;
  assign tm.alarm_min  = alarm_min;

  logic match;

  alarm_match u_match (
    .bus   (tm),
    .match (match)
  );

  logic chime;
`ifdef HOURLY_CHIME_EN
  assign chime = (minute == BCD_59) &&
                 (second >= CHIME_FIRST_SEC) &&
                 (second <= BCD_59);
`else
  assign chime = 1'b0;
`endif

  state_t               state;
  logic [SEC_CNT_W-1:0] sec_cnt;
  logic [1:0]           snooze_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      isTimeUp   <= 1'b0;
      shouldTick <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CP_1Hz && alarm_en && match) begin
            state      <= RINGING;
            sec_cnt    <= '0;
            snooze_cnt <= '0;
            isTimeUp   <= 1'b1;
            shouldTick <= 1'b0;
          end else if (CP_1Hz) begin
            shouldTick <= chime;
          end
        end
        RINGING: begin
          shouldTick <= 1'b0;
          if (!alarm_en || key_stop) begin
            state    <= IDLE;
            isTimeUp <= 1'b0;
          end else if (key_snooze) begin
            if (snooze_cnt < MAX_S) begin
              state      <= SNOOZE;
              snooze_cnt <= snooze_cnt + 2'd1;
              sec_cnt    <= '0;
              isTimeUp   <= 1'b0;
              snoozing   <= 1'b1;
            end else begin
              state    <= IDLE;
              isTimeUp <= 1'b0;
            end
          end else if (CP_1Hz) begin
            if (sec_cnt == RING_LAST) begin
              state    <= IDLE;
              isTimeUp <= 1'b0;
            end else begin
              sec_cnt <= sec_cnt + SEC_CNT_W'(1);
            end
          end
        end
        SNOOZE: begin
          shouldTick <= 1'b0;
          if (!alarm_en || key_stop) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (CP_1Hz) begin
            if (sec_cnt == SNZ_LAST) begin
              state    <= RINGING;
              sec_cnt  <= '0;
              isTimeUp <= 1'b1;
              snoozing <= 1'b0;
            end else begin
              sec_cnt <= sec_cnt + SEC_CNT_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          isTimeUp   <= 1'b0;
          shouldTick <= 1'b0;
          snoozing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// Bench for alarm_chime_ctrl: countdown-style reference model,
// per-cycle compare, directed scenarios and random traffic.
module tb_alarm_chime_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;
`ifdef HOURLY_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cp = 1'b0;
  logic en = 1'b0;
  logic ks = 1'b0;
  logic kz = 1'b0;
  logic up, tick, snz;

  alarm_chime_ctrl_if bus ();

  always #5 clk = ~clk;

  alarm_chime_ctrl #(
    .RING_SEC        (RING_SEC),
    .SNOOZE_SEC      (SNOOZE_SEC),
    .MAX_SNOOZE      (MAX_SNOOZE),
    .CHIME_FIRST_SEC (8'h55)
  ) dut (
    .CLK        (clk),
    .nRST       (rst_n),
    .CP_1Hz     (cp),
    .hour       (bus.hour),
    .minute     (bus.minute),
    .second     (bus.second),
    .alarm_hour (bus.alarm_hour),
    .alarm_min  (bus.alarm_min),
    .alarm_en   (en),
    .key_stop   (ks),
    .key_snooze (kz),
    .isTimeUp   (up),
    .shouldTick (tick),
    .snoozing   (snz)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int al_t = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic put_time(input int s);
    t = ((s % 86400) + 86400) % 86400;
    bus.hour   = bcd(t / 3600);
    bus.minute = bcd((t / 60) % 60);
    bus.second = bcd(t % 60);
  endtask

  task automatic set_alarm(input int h, input int m);
    al_t = h * 3600 + m * 60;
    bus.alarm_hour = bcd(h);
    bus.alarm_min  = bcd(m);
  endtask

  task automatic cyc(input logic s, input logic a, input logic b);
    cp = s; ks = a; kz = b;
    @(posedge clk);
    #1;
    cp = 1'b0; ks = 1'b0; kz = 1'b0;
  endtask

  task automatic sec();
    put_time(t + 1);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ringing/snoozing flags with seconds-left countdown.
  bit m_ring = 0, m_snz = 0, m_tick = 0;
  int m_left = 0, m_used = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ring = 0; m_snz = 0; m_tick = 0;
      m_left = 0; m_used = 0;
    end else if (m_ring || m_snz) begin
      m_tick = 0;
      if (!en || ks) begin
        m_ring = 0; m_snz = 0;
      end else if (m_ring && kz) begin
        m_ring = 0;
        if (m_used < MAX_SNOOZE) begin
          m_used++;
          m_snz = 1;
          m_left = SNOOZE_SEC;
        end
      end else if (cp) begin
        m_left--;
        if (m_left == 0) begin
          if (m_snz) begin
            m_snz = 0; m_ring = 1; m_left = RING_SEC;
          end else begin
            m_ring = 0;
          end
        end
      end
    end else if (cp) begin
      if (en && bus.hour == bus.alarm_hour &&
          bus.minute == bus.alarm_min && bus.second == 8'h00) begin
        m_ring = 1; m_left = RING_SEC; m_used = 0; m_tick = 0;
      end else begin
        m_tick = CHIME_ON && bus.minute == 8'h59 &&
                 bus.second >= 8'h55 && bus.second <= 8'h59;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("isTimeUp", up, m_ring);
      chk("snoozing", snz, m_snz);
      chk("shouldTick", tick, m_tick);
    end
  end

  initial begin
    set_alarm(7, 30);
    put_time(0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_up", up, 1'b0);
    chk("rst_snz", snz, 1'b0);
    chk("rst_tick", tick, 1'b0);

    put_time(7 * 3600 + 29 * 60 + 59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pre_match", up, 1'b0);
    sec();
    chk("ring_start", up, 1'b1);
    repeat (59) sec();
    chk("ring_59", up, 1'b1);
    sec();
    chk("ring_timeout", up, 1'b0);

    put_time(7 * 3600 + 29 * 60 + 59);
    sec();
    chk("ring2", up, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("snz_up", up, 1'b0);
      chk("snz_led", snz, 1'b1);
      repeat (SNOOZE_SEC - 1) sec();
      chk("snz_hold", snz, 1'b1);
      sec();
      chk("rering", up, 1'b1);
      chk("rering_led", snz, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("snz_max_up", up, 1'b0);
    chk("snz_max_led", snz, 1'b0);

    put_time(7 * 3600 + 29 * 60 + 59);
    sec();
    cyc(1'b0, 1'b1, 1'b1);
    chk("stop_wins_up", up, 1'b0);
    chk("stop_wins_led", snz, 1'b0);
    put_time(7 * 3600 + 29 * 60 + 59);
    sec();
    cyc(1'b0, 1'b0, 1'b1);
    chk("snz_again", snz, 1'b1);
    en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("en_drop", snz, 1'b0);
    en = 1'b1;

    put_time(10 * 3600 + 59 * 60 + 53);
    sec();
    chk("chime_54", tick, 1'b0);
    for (int s = 55; s <= 59; s++) begin
      sec();
      chk("chime_on", tick, CHIME_ON);
    end
    sec();
    chk("chime_00", tick, 1'b0);

    set_alarm(9, 59);
    put_time(9 * 3600 + 58 * 60 + 59);
    sec();
    chk("ring_0959", up, 1'b1);
    repeat (59) begin
      sec();
      chk("no_tick_ring", tick, 1'b0);
    end
    chk("still_ring", up, 1'b1);

    #3 rst_n = 1'b0;
    #1;
    chk("arst_up", up, 1'b0);
    chk("arst_snz", snz, 1'b0);
    chk("arst_tick", tick, 1'b0);
    @(posedge clk);
    #1;
    put_time(9 * 3600 + 59 * 60);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_idle", up, 1'b0);
    sec();
    chk("post_rst_01", up, 1'b0);
    put_time(9 * 3600 + 58 * 60 + 59);
    sec();
    chk("post_rst_ring", up, 1'b1);

    set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
    for (int n = 0; n < 8000; n++) begin
      int r;
      logic s;
      r = $urandom_range(0, 999);
      if (!(m_ring || m_snz) && r < 4)
        put_time(al_t - $urandom_range(1, 3));
      else if (r < 8)
        put_time($urandom_range(0, 23) * 3600 + 59 * 60 + 50);
      else if (r >= 997)
        en = ~en;
      s = ($urandom_range(0, 1) == 1);
      if (s) put_time(t + 1);
      cyc(s, $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);
      if (n == 4000) set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
